hist2d_accum_bins: RTL and testbench
====================================

# hist2d_accum_bins

Parametrised 2D IQ histogram accumulator with on-chip bin memory. Each accepted sample with an in-range (I,Q) bin coordinate increments that bin's counter through a fully pipelined read-modify-write, one sample per cycle, including back-to-back hits on the same bin. Sits between the IQ binning stage and the readout/UART path. Adds runtime grid limits, drop counting, a hardware clear sweep and a dedicated readout port.

## Interface
- COORD_W, 8, bits per axis coordinate; memory depth 2^(2*COORD_W)
- CNT_W, 16, bin counter width
- TOT_W, 32, total/dropped sample counter width
- clk100  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- sample_valid  in  1  sample present this cycle
- sample_ready  out  1  sample accepted when sample_valid & sample_ready
- i_bin_coord, q_bin_coord  in  COORD_W each  bin coordinates of sample
- i_bin_num, q_bin_num  in  COORD_W+1 each  active grid size per axis; sampled at accept
- clear_start  in  1  request full histogram clear (one-cycle pulse, ignored unless IDLE)
- busy  out  1  high in DRAIN or CLEAR
- rd_en  in  1  readout request
- rd_i, rd_q  in  COORD_W each  readout bin coordinates
- rd_valid  out  1  rd_data valid strobe
- rd_data  out  CNT_W  bin count
- total_count  out  TOT_W  samples stored
- dropped_count  out  TOT_W  samples rejected (out of grid)

## Operation
- Bin address = {q_bin_coord, i_bin_coord}; memory is simple dual-port BRAM, synchronous read, one write port.
- Accepted sample stored iff i_bin_coord < i_bin_num and q_bin_coord < q_bin_num; otherwise dropped_count += 1 and no memory access. i_bin_num = 0 drops everything.
- Stored sample: bin += 1, total_count += 1 (total_count increments at accept).
- Hazard: any sequence of same-bin samples, any spacing, yields exact final count; in-flight updated values forwarded to the read stage, never stale RAM data.
- FSM: IDLE -> (clear_start) DRAIN -> (pipeline empty) CLEAR -> (last address written) IDLE. Reset enters CLEAR directly (BRAM contents not reset).
- CLEAR writes 0 to addresses 0 .. 2^(2*COORD_W)-1, one per cycle, ascending; total_count and dropped_count zeroed on entry to CLEAR.
- sample_ready = (state == IDLE) & ~rd_en. Readout has priority over samples; rd_en ignored outside IDLE.
- rd_en during a sample in flight returns the count after all previously accepted samples complete.

## Timing
- Reset values: sample_ready 0, busy 1, rd_valid 0, rd_data 0, total_count 0, dropped_count 0, FSM = CLEAR, clear address 0.
- Reset asserted mid-operation: pipeline flushed, clear restarts at address 0.
- Sample accepted cycle T: memory written at rising edge ending T+2; visible to a rd_en issued at T+1 or later.
- Throughput 1 sample/cycle sustained.
- rd_en at cycle T -> rd_valid high for exactly cycle T+2, rd_data held until next read.
- DRAIN lasts <= 2 cycles; CLEAR lasts exactly 2^(2*COORD_W) cycles; busy falls the cycle after the last clear write, sample_ready rises same cycle.
- Counter arithmetic CNT_W/TOT_W unsigned; total/dropped wrap modulo 2^TOT_W.

## Configuration
- HIST2D_SAT_EN defined: bin counter saturates at 2^CNT_W-1 (further hits leave value unchanged, still counted in total_count).
- Undefined: bin counter wraps to 0 after 2^CNT_W-1.

## Test plan
- Reset, COORD_W=4: busy high 256 cycles, then reading all bins returns 0, total/dropped 0.
- Grid 16x16, 5 back-to-back samples at (3,7) then rd (3,7) -> rd_data 5, total_count 5.
- Alternating (1,1),(2,2),(1,1) each cycle, 100 samples -> bin(1,1)=50, bin(2,2)=50 exactly.
- i_bin_num=8, sample (9,0) and (0,9) -> dropped_count 2, bin(9,0) stays 0.
- CNT_W=4, 20 hits one bin -> 15 with HIST2D_SAT_EN, 4 without.
- clear_start with samples in flight -> in-flight samples written, then all bins 0, counters 0; sample_ready low throughout busy.

Source files
------------

// File: rtl/hist2d_accum_bins.sv
`default_nettype none
// ============================================================================
// Module   : hist2d_accum_bins
// Brief    : 2D IQ histogram accumulator. Each accepted in-grid sample
//            increments its bin through a 3-stage read-modify-write pipeline
//            (read issue, modify with forwarding, write), one sample per
//            cycle. Adds drop counting, a hardware clear sweep and a
//            dedicated readout port that shares the RAM read port.
// Options  : HIST2D_SAT_EN - bin counters saturate instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module hist2d_accum_bins #(
  parameter int COORD_W = 8,
  parameter int CNT_W   = 16,
  parameter int TOT_W   = 32
) (
  input  logic               clk100,
  input  logic               reset_n,
  input  logic               sample_valid,
  output logic               sample_ready,
  input  logic [COORD_W-1:0] i_bin_coord,
  input  logic [COORD_W-1:0] q_bin_coord,
  input  logic [COORD_W:0]   i_bin_num,
  input  logic [COORD_W:0]   q_bin_num,
  input  logic               clear_start,
  output logic               busy,
  input  logic               rd_en,
  input  logic [COORD_W-1:0] rd_i,
  input  logic [COORD_W-1:0] rd_q,
  output logic               rd_valid,
  output logic [CNT_W-1:0]   rd_data,
  output logic [TOT_W-1:0]   total_count,
  output logic [TOT_W-1:0]   dropped_count
);

  localparam int ADDR_W = 2 * COORD_W;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   clr_addr;

  // Bin memory: contents are not reset, the clear sweep initialises them.
  logic [CNT_W-1:0]    mem [DEPTH];
  logic [CNT_W-1:0]    ram_q;

  // Stage 1: read issued last cycle, RAM data available now.
  logic                s1_hit;
  logic                s1_rd;
  logic [ADDR_W-1:0]   s1_addr;
  // Stage 2: updated value waiting to be written this cycle.
  logic                s2_valid;
  logic [ADDR_W-1:0]   s2_addr;
  logic [CNT_W-1:0]    s2_data;
  // Copy of the write committed on the same edge as the last RAM read; the
  // RAM returns old data in that case, so the value is forwarded from here.
  logic                s3_valid;
  logic [ADDR_W-1:0]   s3_addr;
  logic [CNT_W-1:0]    s3_data;

  logic                in_idle;
  logic                accept;
  logic                in_grid;
  logic                hit;
  logic                rd_go;
  logic                ram_re;
  logic [ADDR_W-1:0]   ram_raddr;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [CNT_W-1:0]    ram_wdata;
  logic [CNT_W-1:0]    fwd;
  logic [CNT_W-1:0]    incr;
  logic                enter_clear;

  assign in_idle      = (state == ST_IDLE);
  assign sample_ready = in_idle & ~rd_en;
  assign busy         = (state == ST_DRAIN) | (state == ST_CLEAR);
  assign accept       = sample_valid & sample_ready;
  assign in_grid      = ({1'b0, i_bin_coord} < i_bin_num) &
                        ({1'b0, q_bin_coord} < q_bin_num);
  assign hit          = accept & in_grid;
  assign rd_go        = rd_en & in_idle;
  assign ram_re       = rd_go | hit;
  assign ram_raddr    = rd_go ? {rd_q, rd_i} : {q_bin_coord, i_bin_coord};
  assign enter_clear  = (state != ST_CLEAR) & (state_nx == ST_CLEAR);

  // Write port: clear sweep owns it in CLEAR, otherwise stage 2 updates.
  assign ram_we    = s2_valid | (state == ST_CLEAR);
  assign ram_waddr = (state == ST_CLEAR) ? clr_addr : s2_addr;
  assign ram_wdata = (state == ST_CLEAR) ? '0 : s2_data;

  // Newest value of the stage-1 bin: pending write first, then just-written.
  always_comb begin
    fwd = ram_q;
    if (s2_valid && (s2_addr == s1_addr)) begin
      fwd = s2_data;
    end else if (s3_valid && (s3_addr == s1_addr)) begin
      fwd = s3_data;
    end
  end

  // Bin increment, saturating or wrapping depending on the build option.
  always_comb begin
`ifdef HIST2D_SAT_EN
    incr = (fwd == {CNT_W{1'b1}}) ? fwd : fwd + CNT_W'(1);
`else
    incr = fwd + CNT_W'(1);
`endif
  end

  // Synchronous RAM read port shared by samples and readout.
  always_ff @(posedge clk100) begin
    if (ram_re) begin
      ram_q <= mem[ram_raddr];
    end
  end

  // RAM write port.
  always_ff @(posedge clk100) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
  end

  // Pipeline control and forwarding registers; reset flushes everything.
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      s1_hit   <= 1'b0;
      s1_rd    <= 1'b0;
      s1_addr  <= '0;
      s2_valid <= 1'b0;
      s2_addr  <= '0;
      s2_data  <= '0;
      s3_valid <= 1'b0;
      s3_addr  <= '0;
      s3_data  <= '0;
    end else begin
      s1_hit   <= hit;
      s1_rd    <= rd_go;
      s1_addr  <= ram_raddr;
      s2_valid <= s1_hit;
      s2_addr  <= s1_addr;
      s2_data  <= incr;
      s3_valid <= ram_we;
      s3_addr  <= ram_waddr;
      s3_data  <= ram_wdata;
    end
  end

  // Readout result register, held until the next read completes.
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= s1_rd;
      if (s1_rd) begin
        rd_data <= fwd;
      end
    end
  end

  // State register and clear address; reset restarts the sweep at 0.
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_CLEAR) begin
        clr_addr <= clr_addr + ADDR_W'(1);
      end else begin
        clr_addr <= '0;
      end
    end
  end

  // Next state: drain waits for the last read stage to move to the write stage.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (clear_start) state_nx = ST_DRAIN;
      ST_DRAIN: if (!s1_hit) state_nx = ST_CLEAR;
      ST_CLEAR: if (clr_addr == {ADDR_W{1'b1}}) state_nx = ST_IDLE;
      default:  state_nx = ST_CLEAR;
    endcase
  end

  // Sample counters: count at accept, zeroed on entry to the clear sweep.
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      total_count   <= '0;
      dropped_count <= '0;
    end else if (enter_clear) begin
      total_count   <= '0;
      dropped_count <= '0;
    end else begin
      if (hit) begin
        total_count <= total_count + TOT_W'(1);
      end
      if (accept && !in_grid) begin
        dropped_count <= dropped_count + TOT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hist2d_accum_bins.sv
`default_nettype none
// ============================================================================
// Module   : tb_hist2d_accum_bins
// Brief    : Bench for hist2d_accum_bins (COORD_W=4, CNT_W=4, TOT_W=32)
//            with a cycle-level reference model of bins and counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hist2d_accum_bins;

  localparam int CW   = 4;
  localparam int NW   = 4;
  localparam int TW   = 32;
  localparam int SIDE = 1 << CW;
  localparam int NB   = SIDE * SIDE;
  localparam int CMAX = (1 << NW) - 1;
`ifdef HIST2D_SAT_EN
  localparam int EXP50 = 15;
  localparam int EXP20 = 15;
`else
  localparam int EXP50 = 50 % 16;
  localparam int EXP20 = 20 % 16;
`endif

  logic          clk100 = 1'b0;
  logic          reset_n = 1'b1;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic [CW-1:0] i_bin_coord = '0;
  logic [CW-1:0] q_bin_coord = '0;
  logic [CW:0]   i_bin_num = 5'd16;
  logic [CW:0]   q_bin_num = 5'd16;
  logic          clear_start = 1'b0;
  logic          busy;
  logic          rd_en = 1'b0;
  logic [CW-1:0] rd_i = '0;
  logic [CW-1:0] rd_q = '0;
  logic          rd_valid;
  logic [NW-1:0] rd_data;
  logic [TW-1:0] total_count;
  logic [TW-1:0] dropped_count;

  hist2d_accum_bins #(.COORD_W(CW), .CNT_W(NW), .TOT_W(TW)) dut (
    .clk100(clk100), .reset_n(reset_n),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .i_bin_coord(i_bin_coord), .q_bin_coord(q_bin_coord),
    .i_bin_num(i_bin_num), .q_bin_num(q_bin_num),
    .clear_start(clear_start), .busy(busy),
    .rd_en(rd_en), .rd_i(rd_i), .rd_q(rd_q),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .total_count(total_count), .dropped_count(dropped_count)
  );

  always #5 clk100 = ~clk100;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; int val; } rd_t;
  int            cyc = 0;
  int            m_bins [NB];
  logic [TW-1:0] m_total = '0;
  logic [TW-1:0] m_drop = '0;
  int            busy_hi = 100000;
  int            zero_at = -1;
  int            last_acc = -10;
  rd_t           rq [$];
  bit            exp_rv = 1'b0;
  int            exp_rd = 0;

  always @(posedge clk100) cyc <= cyc + 1;

  // Cycle k ends at this edge; the model state afterwards describes cycle k+1.
  always @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      m_total = '0;
      m_drop  = '0;
      busy_hi = cyc + 256;
      zero_at = -1;
      last_acc = -10;
      rq.delete();
      exp_rv = 1'b0;
      exp_rd = 0;
      for (int a = 0; a < NB; a++) m_bins[a] = 0;
    end else begin
      int  k;
      bit  idle;
      bit  acc;
      k    = cyc;
      idle = (k > busy_hi);
      acc  = sample_valid && idle && !rd_en;
      exp_rv = 1'b0;
      if (rq.size() > 0 && rq[0].due == k + 1) begin
        exp_rv = 1'b1;
        exp_rd = rq[0].val;
        void'(rq.pop_front());
      end
      if (rd_en && idle) begin
        rd_t r;
        r.due = k + 2;
        r.val = m_bins[int'(rd_q) * SIDE + int'(rd_i)];
        rq.push_back(r);
      end
      if (acc) begin
        last_acc = k;
        if (int'(i_bin_coord) < int'(i_bin_num) && int'(q_bin_coord) < int'(q_bin_num)) begin
          int a;
          a = int'(q_bin_coord) * SIDE + int'(i_bin_coord);
`ifdef HIST2D_SAT_EN
          if (m_bins[a] < CMAX) m_bins[a] = m_bins[a] + 1;
`else
          m_bins[a] = (m_bins[a] + 1) % (CMAX + 1);
`endif
          m_total = m_total + 1;
        end else begin
          m_drop = m_drop + 1;
        end
      end
      if (clear_start && idle) begin
        zero_at = (k + 2 > last_acc + 3) ? k + 2 : last_acc + 3;
        busy_hi = zero_at + NB - 1;
      end
      if (k + 1 == zero_at) begin
        m_total = '0;
        m_drop  = '0;
        for (int a = 0; a < NB; a++) m_bins[a] = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk100) begin
    chk("busy", busy, (cyc <= busy_hi));
    chk("sample_ready", sample_ready, (cyc > busy_hi) && !rd_en);
    chk("rd_valid", rd_valid, exp_rv);
    chk("rd_data", rd_data, exp_rd);
    chk("total_count", total_count, m_total);
    chk("dropped_count", dropped_count, m_drop);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    chk({"idle_timeout_", nm}, busy, 0);
  endtask

  task automatic do_clear(input string nm);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    wait_idle(nm);
  endtask

  task automatic send_n(input int i, input int q, input int n);
    sample_valid = 1'b1;
    i_bin_coord  = CW'(i);
    q_bin_coord  = CW'(q);
    repeat (n) tick();
    sample_valid = 1'b0;
  endtask

  task automatic read_lit(input int i, input int q, input int exp, input string nm);
    rd_en = 1'b1;
    rd_i  = CW'(i);
    rd_q  = CW'(q);
    tick();
    rd_en = 1'b0;
    tick();
    chk({nm, "_valid"}, rd_valid, 1);
    chk(nm, rd_data, exp);
  endtask

  task automatic read_all();
    for (int a = 0; a < NB; a++) begin
      rd_en = 1'b1;
      rd_i  = CW'(a % SIDE);
      rd_q  = CW'(a / SIDE);
      tick();
    end
    rd_en = 1'b0;
    repeat (3) tick();
  endtask

  task automatic random_phase(input int n);
    for (int c = 0; c < n; c++) begin
      sample_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        i_bin_coord = CW'($urandom_range(0, SIDE - 1));
        q_bin_coord = CW'($urandom_range(0, SIDE - 1));
      end else begin
        i_bin_coord = CW'($urandom_range(0, 3));
        q_bin_coord = CW'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 9) == 0) begin
        i_bin_num = (CW + 1)'($urandom_range(0, SIDE));
        q_bin_num = (CW + 1)'($urandom_range(0, SIDE));
      end else begin
        i_bin_num = (CW + 1)'(SIDE);
        q_bin_num = (CW + 1)'(SIDE);
      end
      rd_en       = ($urandom_range(0, 4) == 0);
      rd_i        = CW'($urandom_range(0, 3));
      rd_q        = CW'($urandom_range(0, 2));
      clear_start = ($urandom_range(0, 599) == 0);
      tick();
    end
    sample_valid = 1'b0;
    rd_en        = 1'b0;
    clear_start  = 1'b0;
    i_bin_num    = (CW + 1)'(SIDE);
    q_bin_num    = (CW + 1)'(SIDE);
    tick();
    wait_idle("random");
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    int bl;
    #1 reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    bl = 0;
    while (busy && bl < 1000) begin
      bl++;
      tick();
    end
    chk("reset_busy_len", bl, NB);
    chk("reset_total", total_count, 0);
    chk("reset_dropped", dropped_count, 0);
    read_all();

    // Five back-to-back hits on (3,7).
    send_n(3, 7, 5);
    read_lit(3, 7, 5, "bin_3_7");
    chk("total_5", total_count, 5);
    chk("model_3_7", m_bins[7 * SIDE + 3], 5);

    // Alternating (1,1),(2,2) every cycle, 100 samples.
    do_clear("alt");
    sample_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      i_bin_coord = CW'((n % 2) + 1);
      q_bin_coord = CW'((n % 2) + 1);
      tick();
    end
    sample_valid = 1'b0;
    read_lit(1, 1, EXP50, "bin_1_1");
    read_lit(2, 2, EXP50, "bin_2_2");
    chk("total_100", total_count, 100);

    // Out-of-grid drops.
    do_clear("drop");
    i_bin_num = 5'd8;
    q_bin_num = 5'd8;
    send_n(9, 0, 1);
    send_n(0, 9, 1);
    chk("dropped_2", dropped_count, 2);
    read_lit(9, 0, 0, "bin_9_0");
    i_bin_num = 5'd0;
    send_n(0, 0, 1);
    chk("dropped_3", dropped_count, 3);
    chk("total_0", total_count, 0);
    i_bin_num = 5'd16;
    q_bin_num = 5'd16;

    // 20 hits on one bin: saturate or wrap.
    do_clear("sat");
    send_n(5, 5, 20);
    read_lit(5, 5, EXP20, "bin_5_5_x20");

    // Clear issued with samples still in flight.
    sample_valid = 1'b1;
    i_bin_coord  = 4'd4;
    q_bin_coord  = 4'd4;
    tick();
    tick();
    clear_start = 1'b1;
    tick();
    clear_start  = 1'b0;
    sample_valid = 1'b0;
    wait_idle("inflight");
    read_lit(4, 4, 0, "bin_4_4_cleared");
    chk("total_cleared", total_count, 0);

    // Randomised traffic, then a full readout.
    random_phase(3000);
    read_all();

    // Reset in the middle of traffic.
    sample_valid = 1'b1;
    i_bin_coord  = 4'd1;
    q_bin_coord  = 4'd1;
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    sample_valid = 1'b0;
    wait_idle("midreset");
    read_all();
    random_phase(800);
    read_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
